spi_sram_burst_controller: RTL and testbench

Parametrised Wishbone-classic slave that turns single bus cycles into SPI mode-0 transactions on a sequential-mode serial SRAM.
- Generalises the single-byte controller in four ways: configurable address width, multi-byte bursts, programmable SCK divider and N chip selects.
- Adds abort handling and an error response for an unmapped chip select.
- Sits between the core's memory bus and the off-chip SRAM pins.

---
 rtl/spi_sram_burst_controller.sv | 155 +++++++++++++++
 tb/tb_spi_sram_burst_controller.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sram_burst_controller.sv
// Wishbone-classic slave that runs each bus cycle as one SPI mode-0 burst
// (command, address, data bytes) against a sequential-mode serial SRAM.
module spi_sram_burst_controller #(
   parameter int ADDR_WIDTH = 24,
   parameter int DATA_BYTES = 1,
   parameter int NUM_CS     = 3,
   parameter int CLK_DIV    = 1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    cyc_i,
   input  logic                    stb_i,
   input  logic [ADDR_WIDTH-1:0]   adr_i,
   input  logic                    we_i,
   input  logic [8*DATA_BYTES-1:0] dat_i,
   output logic                    ack_o,
   output logic                    err_o,
   output logic                    rty_o,
   output logic [8*DATA_BYTES-1:0] dat_o,
   input  logic [2:0]              cs_sel_i,
   output logic                    sck,
   output logic                    mosi,
   input  logic                    miso,
   output logic [NUM_CS-1:0]       cs_n
);
   localparam int DW         = 8 * DATA_BYTES;
   localparam int T          = 8 + ADDR_WIDTH + DW;
   localparam int BW         = $clog2(T);
   localparam int DATA_START = 8 + ADDR_WIDTH;

   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

   state_t            state_r;
   logic [T-1:0]      shift_r;
   logic [DW-1:0]     rx_r;
   logic [BW-1:0]     bit_cnt_r;
   logic [7:0]        div_cnt_r;
   logic              setup_r;
   logic              we_r;
   logic [2:0]        cs_sel_r;
   logic [NUM_CS-1:0] cs_mask_s;
   logic              req_s;
   logic              sel_ok_s;

   // Byte 0 travels first on the wire, so one swap serves both load and capture.
   function automatic logic [DW-1:0] swap_bytes(input logic [DW-1:0] v);
      logic [DW-1:0] r;
      r = '0;
      for (int k = 0; k < DATA_BYTES; k++) begin
         r[8*k +: 8] = v[DW-8-8*k +: 8];
      end
      return r;
   endfunction

   assign rty_o    = 1'b0;
   assign req_s    = cyc_i & stb_i & ~ack_o & ~err_o;
   assign sel_ok_s = (cs_sel_i != 3'd0) && (cs_sel_i <= 3'(NUM_CS));

   // Active-low select pattern for the latched chip-select index
   always_comb begin
      cs_mask_s = '1;
      for (int i = 0; i < NUM_CS; i++) begin
         if (cs_sel_r == 3'(i + 1)) begin
            cs_mask_s[i] = 1'b0;
         end else begin
            cs_mask_s[i] = 1'b1;
         end
      end
   end

   // Transaction sequencer: bus handshake, SCK generation and bit shifting
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r   <= IDLE;
         shift_r   <= '0;
         rx_r      <= '0;
         bit_cnt_r <= '0;
         div_cnt_r <= 8'd0;
         setup_r   <= 1'b0;
         we_r      <= 1'b0;
         cs_sel_r  <= 3'd0;
         ack_o     <= 1'b0;
         err_o     <= 1'b0;
         dat_o     <= '0;
         sck       <= 1'b0;
         mosi      <= 1'b0;
         cs_n      <= '1;
      end else begin
         ack_o <= 1'b0;
         err_o <= 1'b0;
         case (state_r)
            IDLE: begin
               if (req_s && sel_ok_s) begin
                  shift_r   <= {(we_i ? 8'h02 : 8'h03), adr_i, swap_bytes(dat_i)};
                  we_r      <= we_i;
                  cs_sel_r  <= cs_sel_i;
                  rx_r      <= '0;
                  bit_cnt_r <= '0;
                  div_cnt_r <= 8'd0;
                  setup_r   <= 1'b1;
                  state_r   <= SHIFT;
               end else if (req_s) begin
                  err_o <= 1'b1;
               end
            end
            SHIFT: begin
               if (!(cyc_i && stb_i)) begin
                  // Master gave up: release the bus without acknowledging.
                  cs_n    <= '1;
                  sck     <= 1'b0;
                  mosi    <= 1'b0;
                  setup_r <= 1'b0;
                  state_r <= IDLE;
               end else if (setup_r) begin
                  setup_r   <= 1'b0;
                  cs_n      <= cs_mask_s;
                  mosi      <= shift_r[T-1];
                  div_cnt_r <= 8'd0;
               end else if (div_cnt_r != 8'(CLK_DIV - 1)) begin
                  div_cnt_r <= div_cnt_r + 8'd1;
               end else begin
                  div_cnt_r <= 8'd0;
                  if (!sck) begin
                     sck <= 1'b1;
                     if (!we_r && (bit_cnt_r >= BW'(DATA_START))) begin
                        rx_r <= {rx_r[DW-2:0], miso};
                     end
                  end else begin
                     sck <= 1'b0;
                     if (bit_cnt_r == BW'(T - 1)) begin
                        cs_n    <= '1;
                        mosi    <= 1'b0;
                        ack_o   <= 1'b1;
                        state_r <= DONE;
                        if (!we_r) begin
                           dat_o <= swap_bytes(rx_r);
                        end
                     end else begin
                        bit_cnt_r <= bit_cnt_r + BW'(1);
                        mosi      <= shift_r[T-2];
                        shift_r   <= {shift_r[T-2:0], 1'b0};
                     end
                  end
               end
            end
            DONE: begin
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_spi_sram_burst_controller.sv
// Bench for spi_sram_burst_controller: three parameter sets driven from one
// bus, checked every cycle against a timing/bit-stream model of the SPI burst.
module tb_spi_sram_burst_controller;
   localparam int BIG = 1000000000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   logic [2:0]  cyc;
   logic        stb, we;
   logic [23:0] adr;
   logic [31:0] dat;
   logic [2:0]  cs_sel;
   logic [2:0]  ack_v, err_v, rty_v, sck_v, mosi_v, miso_v;
   logic [2:0]  csn [3];
   logic [7:0]  dout0, dout2;
   logic [31:0] dout1;

   spi_sram_burst_controller #(.ADDR_WIDTH(24), .DATA_BYTES(1), .NUM_CS(3), .CLK_DIV(1)) u_dut0 (
      .clk_i(clk), .rst_i(rst), .cyc_i(cyc[0]), .stb_i(stb), .adr_i(adr), .we_i(we),
      .dat_i(dat[7:0]), .ack_o(ack_v[0]), .err_o(err_v[0]), .rty_o(rty_v[0]), .dat_o(dout0),
      .cs_sel_i(cs_sel), .sck(sck_v[0]), .mosi(mosi_v[0]), .miso(miso_v[0]), .cs_n(csn[0]));
   spi_sram_burst_controller #(.ADDR_WIDTH(24), .DATA_BYTES(4), .NUM_CS(3), .CLK_DIV(1)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .cyc_i(cyc[1]), .stb_i(stb), .adr_i(adr), .we_i(we),
      .dat_i(dat), .ack_o(ack_v[1]), .err_o(err_v[1]), .rty_o(rty_v[1]), .dat_o(dout1),
      .cs_sel_i(cs_sel), .sck(sck_v[1]), .mosi(mosi_v[1]), .miso(miso_v[1]), .cs_n(csn[1]));
   spi_sram_burst_controller #(.ADDR_WIDTH(24), .DATA_BYTES(1), .NUM_CS(3), .CLK_DIV(3)) u_dut2 (
      .clk_i(clk), .rst_i(rst), .cyc_i(cyc[2]), .stb_i(stb), .adr_i(adr), .we_i(we),
      .dat_i(dat[7:0]), .ack_o(ack_v[2]), .err_o(err_v[2]), .rty_o(rty_v[2]), .dat_o(dout2),
      .cs_sel_i(cs_sel), .sck(sck_v[2]), .mosi(mosi_v[2]), .miso(miso_v[2]), .cs_n(csn[2]));

   // Model state per instance
   int          db [3] = '{1, 4, 1};
   int          dv [3] = '{1, 1, 3};
   logic        act [3];
   logic        rd [3];
   int          e0 [3];
   int          abort_at [3];
   int          err_at [3];
   logic [2:0]  mask [3];
   logic [7:0]  wb [3][8];
   logic [31:0] dprev [3];
   logic [31:0] dnew [3];
   logic [7:0]  mem [int];

   int checks = 0;
   int errors = 0;

   function automatic int tt(input int i);
      return 32 + 8 * db[i];
   endfunction

   function automatic logic [31:0] dout(input int i);
      case (i)
         0:       return {24'h0, dout0};
         1:       return dout1;
         default: return {24'h0, dout2};
      endcase
   endfunction

   function automatic int key(input int i, input int sel, input int a);
      return (i << 28) | (sel << 24) | (a & 32'h00FF_FFFF);
   endfunction

   function automatic logic [7:0] mem_rd(input int k);
      if (mem.exists(k)) return mem[k];
      return 8'h00;
   endfunction

   function automatic logic wbit(input int i, input int b);
      logic [7:0] by;
      by = wb[i][b / 8];
      return by[7 - (b % 8)];
   endfunction

   // Bit the SRAM returns at wire position b (junk outside the data phase)
   function automatic logic rxbit(input int i, input int b);
      logic [7:0] by;
      int k;
      if (b < 32) return ((b % 2) == 1);
      k  = (b - 32) / 8;
      by = dnew[i][8*k +: 8];
      return by[7 - ((b - 32) % 8)];
   endfunction

   task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s[%0d] got=%h expected=%h at t=%0t", nm, i, got, exp, $time);
      end
   endtask

   // Per-cycle comparison of every output against the model
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         logic e_ack, e_err, e_sck, e_mosi;
         logic [2:0] e_cs;
         logic [31:0] e_dat;
         int n, d, t, b;
         e_ack = 1'b0; e_err = 1'b0; e_sck = 1'b0; e_mosi = 1'b0;
         e_cs = 3'b111; e_dat = dprev[i];
         if (!rst && act[i] && cyc_cnt < abort_at[i]) begin
            n = cyc_cnt - e0[i]; d = dv[i]; t = tt(i);
            if (n >= 1 && n <= 2*d*t) begin
               b      = (n - 1) / (2*d);
               e_sck  = (((n - 1) % (2*d)) >= d) ? 1'b1 : 1'b0;
               e_mosi = wbit(i, b);
               e_cs   = mask[i];
            end else if (n >= 2*d*t + 1) begin
               e_ack = (n == 2*d*t + 1) ? 1'b1 : 1'b0;
               if (rd[i]) e_dat = dnew[i];
            end
         end
         if (!rst && cyc_cnt == err_at[i]) e_err = 1'b1;
         chk("ack", i, 32'(ack_v[i]), 32'(e_ack));
         chk("err", i, 32'(err_v[i]), 32'(e_err));
         chk("rty", i, 32'(rty_v[i]), 32'h0);
         chk("sck", i, 32'(sck_v[i]), 32'(e_sck));
         chk("mosi", i, 32'(mosi_v[i]), 32'(e_mosi));
         chk("cs_n", i, 32'(csn[i]), 32'(e_cs));
         chk("dat_o", i, dout(i), e_dat);
      end
   end

   // SRAM model: correct bit only in the cycle before the sck rising edge
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         int n, d, b;
         logic bt;
         if (act[i] && rd[i]) begin
            n = cyc_cnt - e0[i]; d = dv[i];
            if (n >= d) begin
               b  = (n - d) / (2*d);
               bt = rxbit(i, b);
               miso_v[i] <= (((n - d) % (2*d)) == 0) ? bt : ~bt;
            end else begin
               miso_v[i] <= 1'b1;
            end
         end else begin
            miso_v[i] <= 1'b0;
         end
      end
   end

   // Wire capture on sck rising edges of the selected instance
   int         cap_i = 0;
   logic [2:0] prev_sck = 3'b000;
   logic [2:0] cap_cs;
   logic       capq[$];
   always @(negedge clk) begin
      if (sck_v[cap_i] && !prev_sck[cap_i]) begin
         if (capq.size() == 0) cap_cs <= csn[cap_i];
         capq.push_back(mosi_v[cap_i]);
      end
      prev_sck <= sck_v;
   end

   function automatic logic [7:0] cap_byte(input int k);
      logic [7:0] r;
      r = 8'h00;
      for (int j = 0; j < 8; j++) begin
         if (8*k + j < capq.size()) r[7 - j] = capq[8*k + j];
      end
      return r;
   endfunction

   task automatic start_txn(input int i, input logic w, input logic [23:0] a,
                            input logic [31:0] d, input logic [2:0] sel);
      act[i] = 1'b1; rd[i] = ~w; e0[i] = cyc_cnt + 1; abort_at[i] = BIG;
      mask[i] = 3'b111 & ~(3'b001 << (sel - 3'd1));
      wb[i][0] = w ? 8'h02 : 8'h03;
      wb[i][1] = a[23:16]; wb[i][2] = a[15:8]; wb[i][3] = a[7:0];
      for (int k = 0; k < 4; k++) wb[i][4+k] = d[8*k +: 8];
      dnew[i] = 32'h0;
      for (int k = 0; k < db[i]; k++) begin
         if (w) mem[key(i, int'(sel), int'(a) + k)] = d[8*k +: 8];
         else   dnew[i][8*k +: 8] = mem_rd(key(i, int'(sel), int'(a) + k));
      end
      cyc[i] = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; cs_sel = sel;
   endtask

   task automatic wait_done(input int i, output int n_ack);
      int lim;
      lim = 2*dv[i]*tt(i) + 20;
      n_ack = -1;
      for (int k = 0; k < lim; k++) begin
         @(posedge clk); #1;
         if (cyc_cnt - e0[i] == 5) begin
            adr = ~adr; dat = ~dat; we = ~we; cs_sel = 3'd0;
         end
         if (ack_v[i]) begin
            n_ack = cyc_cnt - e0[i];
            break;
         end
      end
      chk("ack_seen", i, 32'(ack_v[i]), 32'h1);
      cyc[i] = 1'b0; stb = 1'b0;
      @(posedge clk); #1;
      chk("ack_one_cycle", i, 32'(ack_v[i]), 32'h0);
      if (rd[i]) dprev[i] = dnew[i];
      act[i] = 1'b0;
   endtask

   task automatic do_err(input int i, input logic [2:0] sel);
      err_at[i] = cyc_cnt + 1;
      cyc[i] = 1'b1; stb = 1'b1; we = 1'b1; cs_sel = sel;
      @(posedge clk); #1;
      chk("err_pulse", i, 32'(err_v[i]), 32'h1);
      chk("err_cs_idle", i, 32'(csn[i]), 32'h7);
      cyc[i] = 1'b0; stb = 1'b0;
      @(posedge clk); #1;
      chk("err_cleared", i, 32'(err_v[i]), 32'h0);
      chk("err_no_ack", i, 32'(ack_v[i]), 32'h0);
   endtask

   initial begin
      int n;
      rst = 1'b0; cyc = 3'b000; stb = 1'b0; we = 1'b0; adr = 24'h0; dat = 32'h0; cs_sel = 3'd0;
      for (int i = 0; i < 3; i++) begin
         act[i] = 1'b0; rd[i] = 1'b0; e0[i] = 0; abort_at[i] = BIG; err_at[i] = -1;
         mask[i] = 3'b111; dprev[i] = 32'h0; dnew[i] = 32'h0;
      end
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("rst_cs_n", i, 32'(csn[i]), 32'h7);
         chk("rst_sck", i, 32'(sck_v[i]), 32'h0);
         chk("rst_dat_o", i, dout(i), 32'h0);
      end
      rst = 1'b0;
      @(posedge clk); #1;

      // Write 0xA5 to 0x012345 on cs 1
      cap_i = 0; capq.delete();
      start_txn(0, 1'b1, 24'h012345, 32'h0000_00A5, 3'd1);
      wait_done(0, n);
      chk("w_ack_at", 0, n, 81);
      chk("w_sck_edges", 0, capq.size(), 40);
      chk("w_byte0", 0, 32'(cap_byte(0)), 32'h02);
      chk("w_byte1", 0, 32'(cap_byte(1)), 32'h01);
      chk("w_byte2", 0, 32'(cap_byte(2)), 32'h23);
      chk("w_byte3", 0, 32'(cap_byte(3)), 32'h45);
      chk("w_byte4", 0, 32'(cap_byte(4)), 32'hA5);
      chk("w_cs", 0, 32'(cap_cs), 32'h6);

      // Read 0x000010 on cs 3, then a write must leave dat_o alone
      mem[key(0, 3, 32'h10)] = 8'h3C;
      capq.delete();
      start_txn(0, 1'b0, 24'h000010, 32'h0, 3'd3);
      wait_done(0, n);
      chk("r_cmd", 0, 32'(cap_byte(0)), 32'h03);
      chk("r_cs", 0, 32'(cap_cs), 32'h3);
      chk("r_data", 0, dout(0), 32'h3C);
      start_txn(0, 1'b1, 24'h000040, 32'h0000_0099, 3'd2);
      wait_done(0, n);
      chk("w_keeps_dat", 0, dout(0), 32'h3C);

      // Four-byte burst write and read-back
      cap_i = 1; capq.delete();
      start_txn(1, 1'b1, 24'h000100, 32'hDEADBEEF, 3'd1);
      wait_done(1, n);
      chk("b_sck_edges", 1, capq.size(), 64);
      chk("b_byte4", 1, 32'(cap_byte(4)), 32'hEF);
      chk("b_byte5", 1, 32'(cap_byte(5)), 32'hBE);
      chk("b_byte6", 1, 32'(cap_byte(6)), 32'hAD);
      chk("b_byte7", 1, 32'(cap_byte(7)), 32'hDE);
      start_txn(1, 1'b0, 24'h000100, 32'h0, 3'd1);
      wait_done(1, n);
      chk("b_readback", 1, dout(1), 32'hDEADBEEF);

      // Divider of 3
      cap_i = 2; capq.delete();
      start_txn(2, 1'b1, 24'h000020, 32'h0000_005A, 3'd2);
      wait_done(2, n);
      chk("d_ack_at", 2, n, 241);
      chk("d_sck_edges", 2, capq.size(), 40);
      start_txn(2, 1'b0, 24'h000020, 32'h0, 3'd2);
      wait_done(2, n);
      chk("d_readback", 2, dout(2), 32'h5A);

      // Unmapped chip selects
      cap_i = 0; capq.delete();
      do_err(0, 3'd0);
      do_err(0, 3'd4);
      repeat (4) @(posedge clk);
      #1;
      chk("err_no_sck", 0, capq.size(), 0);

      // Abort a read in a high sck phase of bit 10
      mem[key(0, 3, 32'h30)] = 8'hC3;
      start_txn(0, 1'b0, 24'h000030, 32'h0, 3'd3);
      for (int k = 0; k < 40 && (cyc_cnt - e0[0]) < 22; k++) begin
         @(posedge clk); #1;
      end
      chk("ab_sck_high", 0, 32'(sck_v[0]), 32'h1);
      stb = 1'b0; abort_at[0] = cyc_cnt + 1;
      @(posedge clk); #1;
      chk("ab_cs_n", 0, 32'(csn[0]), 32'h7);
      chk("ab_sck", 0, 32'(sck_v[0]), 32'h0);
      chk("ab_no_ack", 0, 32'(ack_v[0]), 32'h0);
      chk("ab_dat_kept", 0, dout(0), 32'h3C);
      cyc[0] = 1'b0;
      act[0] = 1'b0; abort_at[0] = BIG;
      repeat (3) @(posedge clk);
      #1;

      // Reset in the middle of a burst
      start_txn(1, 1'b1, 24'h000300, 32'hCAFEF00D, 3'd3);
      for (int k = 0; k < 40 && (cyc_cnt - e0[1]) < 30; k++) begin
         @(posedge clk); #1;
      end
      chk("rs_cs_low", 1, 32'(csn[1]), 32'h3);
      for (int i = 0; i < 3; i++) begin
         act[i] = 1'b0; dprev[i] = 32'h0;
      end
      cyc = 3'b000; stb = 1'b0;
      rst = 1'b1;
      #1;
      chk("rs_cs_n", 1, 32'(csn[1]), 32'h7);
      chk("rs_sck", 1, 32'(sck_v[1]), 32'h0);
      chk("rs_mosi", 1, 32'(mosi_v[1]), 32'h0);
      chk("rs_ack", 1, 32'(ack_v[1]), 32'h0);
      chk("rs_dat_o", 1, dout(1), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Normal traffic after abort and reset
      start_txn(1, 1'b1, 24'h000200, 32'h11223344, 3'd2);
      wait_done(1, n);
      start_txn(1, 1'b0, 24'h000200, 32'h0, 3'd2);
      wait_done(1, n);
      chk("post_rst_read", 1, dout(1), 32'h11223344);
      start_txn(0, 1'b0, 24'h000010, 32'h0, 3'd3);
      wait_done(0, n);
      chk("post_abort_read", 0, dout(0), 32'h3C);

      repeat (2) @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
